// File: rtl/mips_multi_pkg.sv
// rtl/mips_multi_pkg.sv - shared encodings for the multicycle MIPS control FSM
package mips_multi_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_ADDI_EX = 4'd10,
      S_ADDI_WB = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       reg_dst;
   } ctrl_t;

endpackage

// File: rtl/control_multi_if.sv
// rtl/control_multi_if.sv - datapath control bus between the FSM (master) and datapath (slave)
interface control_multi_if #(parameter int STATE_W = 4);

   logic [5:0]         opcode;
   logic               mem_ready;
   logic               PCWrite;
   logic               PCWriteCond;
   logic               IorD;
   logic               MemRead;
   logic               MemWrite;
   logic               MemtoReg;
   logic               IRWrite;
   logic [1:0]         PCSource;
   logic [1:0]         ALUOp;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic               RegWrite;
   logic               RegDst;
   logic               illegal;
   logic [STATE_W-1:0] state_o;

   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal, state_o
   );

   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal, state_o
   );

endinterface

// File: rtl/control_multi.sv
// rtl/control_multi.sv - Moore control FSM sequencing the multicycle MIPS datapath
// Optional addi support is built when CONTROL_MULTI_ADDI_EN is defined.
module control_multi
   import mips_multi_pkg::*;
#(
   parameter int USE_READY = 1,
   parameter int STATE_W   = 4
) (
   input  logic            clk,
   input  logic            reset,
   control_multi_if.master bus
);

   state_t state;
   state_t state_nxt;
   ctrl_t  ctrl_c;
   ctrl_t  ctrl;
   logic   illegal_c;
   logic   rdy;

   assign rdy = (USE_READY != 0) ? bus.mem_ready : 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_FETCH;
      illegal_c = 1'b0;
      case (state)
         S_FETCH:   state_nxt = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_EXEC;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_J:         state_nxt = S_JUMP;
`ifdef CONTROL_MULTI_ADDI_EN
               OP_ADDI:      state_nxt = S_ADDI_EX;
`endif
               // PC was already bumped in FETCH, so dropping back is a NOP
               default: begin
                  state_nxt = S_FETCH;
                  illegal_c = 1'b1;
               end
            endcase
         end
         S_MEMADR:  state_nxt = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_nxt = rdy ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_nxt = S_FETCH;
         S_MEMWR:   state_nxt = rdy ? S_FETCH : S_MEMWR;
         S_EXEC:    state_nxt = S_RWB;
         S_RWB:     state_nxt = S_FETCH;
         S_BRANCH:  state_nxt = S_FETCH;
         S_JUMP:    state_nxt = S_FETCH;
`ifdef CONTROL_MULTI_ADDI_EN
         S_ADDI_EX: state_nxt = S_ADDI_WB;
         S_ADDI_WB: state_nxt = S_FETCH;
`endif
         default:   state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      ctrl_c = '0;
      case (state)
         S_FETCH: begin
            ctrl_c.mem_read  = 1'b1;
            ctrl_c.alu_src_b = SRCB_FOUR;
            ctrl_c.alu_op    = ALUOP_ADD;
            ctrl_c.pc_source = PCSRC_ALU;
            ctrl_c.ir_write  = rdy;
            ctrl_c.pc_write  = rdy;
         end
         S_DECODE: begin
            ctrl_c.alu_src_b = SRCB_IMM_SH;
            ctrl_c.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRCB_IMM;
            ctrl_c.alu_op    = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctrl_c.mem_read = 1'b1;
            ctrl_c.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl_c.reg_write  = 1'b1;
            ctrl_c.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl_c.mem_write = 1'b1;
            ctrl_c.iord      = 1'b1;
         end
         S_EXEC: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRCB_B;
            ctrl_c.alu_op    = ALUOP_FUNCT;
         end
         S_RWB: begin
            ctrl_c.reg_write = 1'b1;
            ctrl_c.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl_c.alu_src_a     = 1'b1;
            ctrl_c.alu_src_b     = SRCB_B;
            ctrl_c.alu_op        = ALUOP_SUB;
            ctrl_c.pc_write_cond = 1'b1;
            ctrl_c.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_source = PCSRC_JUMP;
         end
`ifdef CONTROL_MULTI_ADDI_EN
         S_ADDI_EX: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRCB_IMM;
            ctrl_c.alu_op    = ALUOP_ADD;
         end
         S_ADDI_WB: begin
            ctrl_c.reg_write = 1'b1;
         end
`endif
         default: ctrl_c = '0;
      endcase
   end

   // Reset overrides the FETCH decode so no request escapes while held in reset
   assign ctrl = reset ? ctrl_c : '0;

   assign bus.PCWrite     = ctrl.pc_write;
   assign bus.PCWriteCond = ctrl.pc_write_cond;
   assign bus.IorD        = ctrl.iord;
   assign bus.MemRead     = ctrl.mem_read;
   assign bus.MemWrite    = ctrl.mem_write;
   assign bus.MemtoReg    = ctrl.mem_to_reg;
   assign bus.IRWrite     = ctrl.ir_write;
   assign bus.PCSource    = ctrl.pc_source;
   assign bus.ALUOp       = ctrl.alu_op;
   assign bus.ALUSrcA     = ctrl.alu_src_a;
   assign bus.ALUSrcB     = ctrl.alu_src_b;
   assign bus.RegWrite    = ctrl.reg_write;
   assign bus.RegDst      = ctrl.reg_dst;
   assign bus.illegal     = reset & illegal_c;
   assign bus.state_o     = STATE_W'(state);

endmodule

// File: tb/tb_control_multi.sv
// tb/tb_control_multi.sv - directed self-checking bench for control_multi
module tb_control_multi;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   int   mw_cycles;
   int   mw_commits;

   control_multi_if #(.STATE_W(4)) bus();

   control_multi #(.USE_READY(1), .STATE_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource,ALUOp,ALUSrcA,ALUSrcB,RegWrite,RegDst}
   function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic r);
      case (s)
         4'd0:  exp_ctrl = {r, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, r,    2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0};
         4'd1:  exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0};
         4'd2:  exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0};
         4'd3:  exp_ctrl = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
         4'd4:  exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
         4'd5:  exp_ctrl = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
         4'd6:  exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0};
         4'd7:  exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1};
         4'd8:  exp_ctrl = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
         4'd9:  exp_ctrl = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
         4'd10: exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0};
         4'd11: exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
         default: exp_ctrl = 16'h0000;
      endcase
   endfunction

   task automatic adv();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [3:0] s, input logic ill);
      logic [15:0] got;
      logic [15:0] exp;
      #1;
      got = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg,
             bus.IRWrite, bus.PCSource, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.RegDst};
      exp = reset ? exp_ctrl(s, bus.mem_ready) : 16'h0000;
      tests++;
      assert (bus.state_o === s) else begin
         fails++;
         $error("FAIL %s.state: got %0d expected %0d", tag, bus.state_o, s);
      end
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s.ctrl: got %h expected %h", tag, got, exp);
      end
      tests++;
      assert (bus.illegal === ill) else begin
         fails++;
         $error("FAIL %s.illegal: got %b expected %b", tag, bus.illegal, ill);
      end
      if (bus.MemWrite === 1'b1) mw_cycles++;
      if (bus.MemWrite === 1'b1 && bus.mem_ready === 1'b1) mw_commits++;
   endtask

   initial begin
      reset         = 1'b0;
      bus.mem_ready = 1'b1;
      bus.opcode    = 6'h00;

      for (int i = 0; i < 3; i++) begin
         adv();
         check("reset", 4'd0, 1'b0);
      end

      reset = 1'b1;
      check("fetch_after_reset", 4'd0, 1'b0);

      // lw, zero wait
      bus.opcode = 6'h23;
      adv(); check("lw.decode", 4'd1, 1'b0);
      adv(); check("lw.memadr", 4'd2, 1'b0);
      adv(); check("lw.memrd", 4'd3, 1'b0);
      adv(); check("lw.memwb", 4'd4, 1'b0);
      adv(); check("lw.fetch", 4'd0, 1'b0);

      // sw with two wait cycles in MEMWR
      bus.opcode = 6'h2B;
      mw_cycles  = 0;
      mw_commits = 0;
      adv(); check("sw.decode", 4'd1, 1'b0);
      adv(); check("sw.memadr", 4'd2, 1'b0);
      adv(); bus.mem_ready = 1'b0; check("sw.memwr0", 4'd5, 1'b0);
      adv(); check("sw.memwr1", 4'd5, 1'b0);
      adv(); bus.mem_ready = 1'b1; check("sw.memwr2", 4'd5, 1'b0);
      adv(); check("sw.fetch", 4'd0, 1'b0);
      tests++;
      assert (mw_cycles === 3) else begin
         fails++;
         $error("FAIL sw.mw_cycles: got %0d expected 3", mw_cycles);
      end
      tests++;
      assert (mw_commits === 1) else begin
         fails++;
         $error("FAIL sw.mw_commits: got %0d expected 1", mw_commits);
      end

      // FETCH stalled for 4 cycles, then R-type
      bus.mem_ready = 1'b0;
      bus.opcode    = 6'h00;
      check("fwait.0", 4'd0, 1'b0);
      for (int i = 1; i < 4; i++) begin
         adv();
         check("fwait.n", 4'd0, 1'b0);
      end
      adv(); bus.mem_ready = 1'b1; check("fwait.ready", 4'd0, 1'b0);
      adv(); check("r.decode", 4'd1, 1'b0);
      adv(); check("r.exec", 4'd6, 1'b0);
      adv(); check("r.rwb", 4'd7, 1'b0);
      adv(); check("r.fetch", 4'd0, 1'b0);

      bus.opcode = 6'h04;
      adv(); check("beq.decode", 4'd1, 1'b0);
      adv(); check("beq.branch", 4'd8, 1'b0);
      adv(); check("beq.fetch", 4'd0, 1'b0);

      bus.opcode = 6'h02;
      adv(); check("j.decode", 4'd1, 1'b0);
      adv(); check("j.jump", 4'd9, 1'b0);
      adv(); check("j.fetch", 4'd0, 1'b0);

      bus.opcode = 6'h3F;
      adv(); check("ill.decode", 4'd1, 1'b1);
      adv(); check("ill.fetch", 4'd0, 1'b0);

      bus.opcode = 6'h08;
`ifdef CONTROL_MULTI_ADDI_EN
      adv(); check("addi.decode", 4'd1, 1'b0);
      adv(); check("addi.ex", 4'd10, 1'b0);
      adv(); check("addi.wb", 4'd11, 1'b0);
      adv(); check("addi.fetch", 4'd0, 1'b0);
`else
      adv(); check("addi.decode", 4'd1, 1'b1);
      adv(); check("addi.fetch", 4'd0, 1'b0);
`endif

      // abort a pending store with asynchronous reset
      bus.opcode = 6'h2B;
      adv(); check("abort.decode", 4'd1, 1'b0);
      adv(); check("abort.memadr", 4'd2, 1'b0);
      adv(); bus.mem_ready = 1'b0; check("abort.memwr", 4'd5, 1'b0);
      reset = 1'b0;
      check("abort.async", 4'd0, 1'b0);
      bus.mem_ready = 1'b1;
      adv(); check("abort.held", 4'd0, 1'b0);
      reset = 1'b1;
      check("abort.release", 4'd0, 1'b0);
      bus.opcode = 6'h00;
      adv(); check("abort.decode2", 4'd1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
